// File: rtl/mdio_pkg.sv
// Shared types and frame constants for the Clause-22 MDIO master.
package mdio_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_HEADER,
        S_TA,
        S_DATA
    } state_t;

    localparam logic [1:0] ST_CODE  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] TA_WRITE = 2'b10;

    localparam int HEADER_BITS = 14;
    localparam int TA_BITS     = 2;
    localparam int DATA_BITS   = 16;

    // Reads leave TA/DATA as ones so the idle pad value stays high while released.
    function automatic logic [31:0] build_frame(input logic       write,
                                                input logic [4:0] phy_addr,
                                                input logic [4:0] reg_addr,
                                                input logic [15:0] wdata);
        if (write)
            return {ST_CODE, OP_WRITE, phy_addr, reg_addr, TA_WRITE, wdata};
        else
            return {ST_CODE, OP_READ, phy_addr, reg_addr, 2'b11, 16'hFFFF};
    endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC divider: one MDC half-period every CLK_DIV clk cycles while run is high.
module mdio_clk_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic mdc,
    output logic fall_tick,
    output logic rise_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] WRAP = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_reg;
    logic          mdc_reg;
    logic          wrap;

    assign wrap      = run && (cnt_reg == WRAP);
    // The wrap that ends a high half starts the next bit's low half.
    assign fall_tick = wrap && mdc_reg;
    assign rise_tick = wrap && !mdc_reg;
    assign mdc       = mdc_reg;

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cnt_reg <= '0;
            mdc_reg <= 1'b0;
        end else if (cnt_reg == WRAP) begin
            cnt_reg <= '0;
            mdc_reg <= ~mdc_reg;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/mdio_frame_controller.sv
// Clause-22 MDIO master: sequences one register-access frame per command
// and returns read data / turnaround status on a one-cycle response pulse.
module mdio_frame_controller
    import mdio_pkg::*;
#(
    parameter int CLK_DIV       = 25,
    parameter int PREAMBLE_BITS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy,
    output logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oen
);

    localparam int CNT_MAX = (PREAMBLE_BITS > DATA_BITS) ? PREAMBLE_BITS : DATA_BITS;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HEADER_BITS - 1);
    localparam logic [CNT_W-1:0] TA_LAST   = CNT_W'(TA_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] bit_cnt_reg;
    logic [31:0]      tx_reg;
    logic [15:0]      rx_reg;
    logic             write_reg;
    logic             ta_err_reg;
    logic             run_reg;
    logic             mdio_out_reg;
    logic             mdio_oen_reg;
    logic             rsp_valid_reg;
    logic [15:0]      rsp_rdata_reg;
    logic             rsp_error_reg;
    logic [31:0]      frame;
    logic             fall_tick;
    logic             rise_tick;

    assign frame     = build_frame(cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata);
    assign cmd_ready = (state_reg == S_IDLE);
    assign busy      = (state_reg != S_IDLE);
    assign mdio_out  = mdio_out_reg;
    assign mdio_oen  = mdio_oen_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_error = rsp_error_reg;

    mdio_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk      (clk),
        .reset    (reset),
        .run      (run_reg),
        .mdc      (mdc),
        .fall_tick(fall_tick),
        .rise_tick(rise_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            bit_cnt_reg   <= '0;
            tx_reg        <= '0;
            rx_reg        <= '0;
            write_reg     <= 1'b0;
            ta_err_reg    <= 1'b0;
            run_reg       <= 1'b0;
            mdio_out_reg  <= 1'b1;
            mdio_oen_reg  <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_error_reg <= 1'b0;
        end else begin
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (cmd_valid) begin
                        write_reg    <= cmd_write;
                        ta_err_reg   <= 1'b0;
                        run_reg      <= 1'b1;
                        mdio_oen_reg <= 1'b0;
                        if (PREAMBLE_BITS > 0) begin
                            state_reg    <= S_PREAMBLE;
                            bit_cnt_reg  <= PRE_LAST;
                            mdio_out_reg <= 1'b1;
                            tx_reg       <= frame;
                        end else begin
                            state_reg    <= S_HEADER;
                            bit_cnt_reg  <= HDR_LAST;
                            mdio_out_reg <= frame[31];
                            tx_reg       <= {frame[30:0], 1'b0};
                        end
                    end
                end
                S_PREAMBLE: begin
                    if (fall_tick) begin
                        if (bit_cnt_reg == '0) begin
                            state_reg    <= S_HEADER;
                            bit_cnt_reg  <= HDR_LAST;
                            mdio_out_reg <= tx_reg[31];
                            tx_reg       <= {tx_reg[30:0], 1'b0};
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg - 1'b1;
                        end
                    end
                end
                S_HEADER: begin
                    if (fall_tick) begin
                        mdio_out_reg <= tx_reg[31];
                        tx_reg       <= {tx_reg[30:0], 1'b0};
                        if (bit_cnt_reg == '0) begin
                            state_reg    <= S_TA;
                            bit_cnt_reg  <= TA_LAST;
                            mdio_oen_reg <= ~write_reg;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg - 1'b1;
                        end
                    end
                end
                S_TA: begin
                    // Only the second TA bit must be pulled low by the PHY.
                    if (rise_tick && bit_cnt_reg == '0)
                        ta_err_reg <= mdio_in;
                    if (fall_tick) begin
                        mdio_out_reg <= tx_reg[31];
                        tx_reg       <= {tx_reg[30:0], 1'b0};
                        if (bit_cnt_reg == '0) begin
                            state_reg   <= S_DATA;
                            bit_cnt_reg <= DATA_LAST;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg - 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (rise_tick)
                        rx_reg <= {rx_reg[14:0], mdio_in};
                    if (fall_tick) begin
                        if (bit_cnt_reg == '0) begin
                            state_reg     <= S_IDLE;
                            run_reg       <= 1'b0;
                            mdio_out_reg  <= 1'b1;
                            mdio_oen_reg  <= 1'b1;
                            rsp_valid_reg <= 1'b1;
                            rsp_rdata_reg <= write_reg ? 16'h0000 : rx_reg;
                            rsp_error_reg <= write_reg ? 1'b0 : ta_err_reg;
                        end else begin
                            mdio_out_reg <= tx_reg[31];
                            tx_reg       <= {tx_reg[30:0], 1'b0};
                            bit_cnt_reg  <= bit_cnt_reg - 1'b1;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule
